// File: rtl/kernel_sequencer_pkg.sv
// Shared constants and helpers for the kernel sequencer.
// Holds the bank geometry, the row-select encoding and the select-advance rule.
package kernel_sequencer_pkg;

  localparam int KERNEL_WORDS = 12;
  localparam int TAP_WORDS    = 9;
  localparam int WCNT_W       = 4;

  localparam logic [1:0] SEL_ROW0 = 2'd0;
  localparam logic [1:0] SEL_ROW1 = 2'd1;
  localparam logic [1:0] SEL_ROW2 = 2'd2;
  localparam logic [1:0] SEL_BIAS = 2'd3;

  typedef logic [WCNT_W-1:0] wcnt_t;

  localparam wcnt_t LAST_IDX = wcnt_t'(KERNEL_WORDS - 1);

  // Bias is only visited once, right after a swap; rows then cycle 0,1,2.
  function automatic logic [1:0] next_sel(input logic [1:0] cur);
    logic [1:0] nxt;
    nxt = SEL_ROW0;
    case (cur)
      SEL_BIAS: nxt = SEL_ROW0;
      SEL_ROW0: nxt = SEL_ROW1;
      SEL_ROW1: nxt = SEL_ROW2;
      default:  nxt = SEL_ROW0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/kernel_sequencer_bank.sv
// Twelve-word register file: indexed single-word write, whole-bank parallel load, flat read.
// Used once as the stream-facing shadow bank and once as the output-facing active bank.
module kernel_bank_reg
  import kernel_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  wcnt_t                              waddr,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic                               load,
  input  logic [KERNEL_WORDS*DATA_WIDTH-1:0] load_data,
  output logic [KERNEL_WORDS*DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] word_reg [KERNEL_WORDS];

  for (genvar gi = 0; gi < KERNEL_WORDS; gi++) begin : g_word
    // A parallel load overrides a concurrent indexed write to the same word.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_reg[gi] <= '0;
      end else if (load) begin
        word_reg[gi] <= load_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end else if (we && (waddr == wcnt_t'(gi))) begin
        word_reg[gi] <= wdata;
      end
    end

    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg[gi];
  end

endmodule

// File: rtl/kernel_sequencer.sv
// Double-buffered 3x3 kernel + bias loader feeding a kernel switch row select.
// The "release" command port is named release_kernel because release is a reserved word.
module kernel_sequencer
  import kernel_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  input  logic                    step,
  input  logic                    release_kernel,
  output logic                    kvalid,
  output logic [1:0]              sel,
  output logic [DATA_WIDTH-1:0]   K1,
  output logic [DATA_WIDTH-1:0]   K2,
  output logic [DATA_WIDTH-1:0]   K3,
  output logic [DATA_WIDTH-1:0]   K4,
  output logic [DATA_WIDTH-1:0]   K5,
  output logic [DATA_WIDTH-1:0]   K6,
  output logic [DATA_WIDTH-1:0]   K7,
  output logic [DATA_WIDTH-1:0]   K8,
  output logic [DATA_WIDTH-1:0]   K9,
  output logic [3*DATA_WIDTH-1:0] bias,
  output logic                    err
);

  wcnt_t      wcnt_reg, wcnt_next;
  logic       shadow_full_reg, shadow_full_next;
  logic       s_ready_reg, s_ready_next;
  logic       kvalid_reg, kvalid_next;
  logic [1:0] sel_reg, sel_next;
  logic       err_reg, err_next;

  logic accept;
  logic wr_en;
  logic swap;

  logic [KERNEL_WORDS*DATA_WIDTH-1:0] shadow_flat;
  logic [KERNEL_WORDS*DATA_WIDTH-1:0] active_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_reg        <= '0;
      shadow_full_reg <= 1'b0;
      s_ready_reg     <= 1'b1;
      kvalid_reg      <= 1'b0;
      sel_reg         <= SEL_BIAS;
      err_reg         <= 1'b0;
    end else begin
      wcnt_reg        <= wcnt_next;
      shadow_full_reg <= shadow_full_next;
      s_ready_reg     <= s_ready_next;
      kvalid_reg      <= kvalid_next;
      sel_reg         <= sel_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    wcnt_next        = wcnt_reg;
    shadow_full_next = shadow_full_reg;
    kvalid_next      = kvalid_reg;
    sel_next         = sel_reg;
    err_next         = err_reg;
    wr_en            = 1'b0;

    // s_ready_reg always equals !shadow_full_reg, so accept and swap never coincide.
    accept = s_valid && s_ready_reg;
    swap   = shadow_full_reg && (!kvalid_reg || release_kernel);

    if (accept) begin
      if (s_last && (wcnt_reg != LAST_IDX)) begin
        wcnt_next = '0;
        err_next  = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (wcnt_reg == LAST_IDX) begin
          wcnt_next        = '0;
          shadow_full_next = 1'b1;
          if (!s_last) begin
            err_next = 1'b1;
          end
        end else begin
          wcnt_next = wcnt_reg + 1'b1;
        end
      end
    end

    if (swap) begin
      shadow_full_next = 1'b0;
      kvalid_next      = 1'b1;
      sel_next         = SEL_BIAS;
    end else if (release_kernel && kvalid_reg) begin
      kvalid_next = 1'b0;
    end else if (step && kvalid_reg) begin
      sel_next = next_sel(sel_reg);
    end

    s_ready_next = !shadow_full_next;
  end

  kernel_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .we        (wr_en),
    .waddr     (wcnt_reg),
    .wdata     (s_data),
    .load      (1'b0),
    .load_data ('0),
    .rdata     (shadow_flat)
  );

  kernel_bank_reg #(.DATA_WIDTH(DATA_WIDTH)) u_active (
    .clk       (clk),
    .rst       (rst),
    .we        (1'b0),
    .waddr     ('0),
    .wdata     ('0),
    .load      (swap),
    .load_data (shadow_flat),
    .rdata     (active_flat)
  );

  assign s_ready = s_ready_reg;
  assign kvalid  = kvalid_reg;
  assign sel     = sel_reg;
  assign err     = err_reg;

  assign K1   = active_flat[0*DATA_WIDTH +: DATA_WIDTH];
  assign K2   = active_flat[1*DATA_WIDTH +: DATA_WIDTH];
  assign K3   = active_flat[2*DATA_WIDTH +: DATA_WIDTH];
  assign K4   = active_flat[3*DATA_WIDTH +: DATA_WIDTH];
  assign K5   = active_flat[4*DATA_WIDTH +: DATA_WIDTH];
  assign K6   = active_flat[5*DATA_WIDTH +: DATA_WIDTH];
  assign K7   = active_flat[6*DATA_WIDTH +: DATA_WIDTH];
  assign K8   = active_flat[7*DATA_WIDTH +: DATA_WIDTH];
  assign K9   = active_flat[8*DATA_WIDTH +: DATA_WIDTH];
  assign bias = active_flat[KERNEL_WORDS*DATA_WIDTH-1 : TAP_WORDS*DATA_WIDTH];

endmodule

// File: tb/tb_kernel_sequencer.sv
// Self-checking bench for kernel_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a frame-level model built from queues and arrays.
module tb_kernel_sequencer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          step = 1'b0;
  logic          release_kernel = 1'b0;
  logic          kvalid;
  logic [1:0]    sel;
  logic [DW-1:0] K1, K2, K3, K4, K5, K6, K7, K8, K9;
  logic [3*DW-1:0] bias;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model state: partial/complete shadow frame as a queue, active kernel as an array.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_act[12];
  bit            m_full;
  bit            m_kv;
  bit            m_err;
  int            m_sel;

  kernel_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .step(step), .release_kernel(release_kernel), .kvalid(kvalid),
    .sel(sel), .K1(K1), .K2(K2), .K3(K3), .K4(K4), .K5(K5), .K6(K6), .K7(K7),
    .K8(K8), .K9(K9), .bias(bias), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit swap, acc;
    if (rst) begin
      m_q.delete();
      foreach (m_act[i]) m_act[i] = '0;
      m_full = 0; m_kv = 0; m_err = 0; m_sel = 3;
      return;
    end
    swap = m_full && (!m_kv || release_kernel);
    acc  = s_valid && !m_full;
    if (acc) begin
      if (s_last && m_q.size() < 11) begin
        m_q.delete();
        m_err = 1;
      end else begin
        m_q.push_back(s_data);
        if (m_q.size() == 12) begin
          m_full = 1;
          if (!s_last) m_err = 1;
        end
      end
    end
    if (swap) begin
      for (int i = 0; i < 12; i++) m_act[i] = m_q[i];
      m_q.delete();
      m_full = 0; m_kv = 1; m_sel = 3;
      $display("swap t=%0t: K1=%h K9=%h bias=%h%h%h", $time, m_act[0], m_act[8],
               m_act[11], m_act[10], m_act[9]);
    end else if (release_kernel && m_kv) begin
      m_kv = 0;
    end else if (step && m_kv) begin
      m_sel = (m_sel == 3) ? 0 : (m_sel + 1) % 3;
    end
  endtask

  task automatic compare();
    logic [191:0] got, exp;
    got = {bias, K9, K8, K7, K6, K5, K4, K3, K2, K1};
    exp = '0;
    for (int i = 0; i < 12; i++) exp[i*16 +: 16] = m_act[i];
    check("s_ready", s_ready, !m_full);
    check("kvalid", kvalid, m_kv);
    check("sel", sel, m_sel);
    check("err", err, m_err);
    check("taps", got, exp);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    s_valid = 0; s_last = 0; step = 0; release_kernel = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Streams n words base, base+1, ...; s_last on word index last_at (-1 = never).
  task automatic send_frame(input logic [DW-1:0] base, input int last_at, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_data  = base + DW'(i);
      s_last  = (i == last_at);
      guard = 0;
      while (!s_ready && guard < 40) begin
        tick();
        guard++;
      end
      if (guard >= 40) check("stall_bound", s_ready, 1);
      tick();
    end
    idle();
  endtask

  task automatic pulse_step();
    step = 1; tick(); step = 0;
  endtask

  task automatic pulse_release();
    release_kernel = 1; tick(); release_kernel = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", s_ready, 1);
    check("rst_sel", sel, 3);

    // Basic load 1..12
    send_frame(16'd1, 11, 12);
    check("basic_full_ready", s_ready, 0);
    tick();
    check("basic_k1", K1, 16'd1);
    check("basic_k9", K9, 16'd9);
    check("basic_bias", bias, 48'h000C_000B_000A);
    check("basic_kvalid", kvalid, 1);

    // Select walk, then step while idle
    for (int i = 0; i < 5; i++) pulse_step();
    check("walk_sel", sel, 1);
    pulse_release();
    pulse_step();
    check("idle_step_sel", sel, 1);

    // Double buffer
    do_reset();
    send_frame(16'h10, 11, 12);
    tick();
    send_frame(16'h20, 11, 12);
    tick();
    check("dbuf_ready", s_ready, 0);
    check("dbuf_k1_old", K1, 16'h10);
    pulse_release();
    check("dbuf_k1_new", K1, 16'h20);
    check("dbuf_sel", sel, 3);
    tick();
    check("dbuf_ready_after", s_ready, 1);

    // Early s_last, then a clean frame
    send_frame(16'h30, 5, 6);
    tick();
    check("early_err", err, 1);
    check("early_kvalid", kvalid, 1);
    send_frame(16'h40, 11, 12);
    tick();
    pulse_release();
    check("early_reload_k1", K1, 16'h40);

    // Missing s_last
    do_reset();
    send_frame(16'h50, -1, 12);
    tick();
    check("nolast_kvalid", kvalid, 1);
    check("nolast_err", err, 1);
    check("nolast_k1", K1, 16'h50);

    // Reset mid-load with a kernel active
    do_reset();
    send_frame(16'h60, 11, 12);
    tick();
    send_frame(16'h70, -1, 6);
    do_reset();
    check("midrst_kvalid", kvalid, 0);
    check("midrst_k1", K1, 16'h0);
    send_frame(16'h80, 11, 12);
    tick();
    check("midrst_reload_k1", K1, 16'h80);
    check("midrst_reload_k2", K2, 16'h81);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      s_valid        = ($urandom_range(0, 9) < 7);
      s_data         = DW'($urandom);
      s_last         = (m_q.size() == 11) ^ ($urandom_range(0, 19) == 0);
      step           = ($urandom_range(0, 9) < 3);
      release_kernel = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
